// File: rtl/ppu_mosaic_pkg.sv
// Shared mosaic types: default block-size width, size type, and a per-layer yofs slice helper.
// Pure declarations; no timing or flow control of its own.
package ppu_mosaic_pkg;

    localparam int SIZE_W_DEF = 4;
    localparam int NUM_BG_MAX = 8;

    typedef logic [SIZE_W_DEF-1:0] mosaic_size_t;

    // Pull layer idx out of a packed yofs_subtract bus padded to the maximum layer count.
    function automatic mosaic_size_t yofs_slice(input logic [NUM_BG_MAX*SIZE_W_DEF-1:0] bus,
                                                input int idx);
        return bus[idx*SIZE_W_DEF +: SIZE_W_DEF];
    endfunction

endpackage

// File: rtl/mosaic_axis_ctr.sv
// Block-position counter for one mosaic axis: wraps to 0 once it reaches the block size, clear wins.
// Updates one cycle after a qualified step/clear; never stalls.
module mosaic_axis_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         clear,
    input  logic [W-1:0] size,
    output logic [W-1:0] out
);

    // >= rather than == so a shrink below the current position wraps on the next step.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (clear) begin
            out <= '0;
        end else if (step) begin
            out <= (out >= size) ? '0 : out + W'(1);
        end
    end

endmodule

// File: rtl/mosaic_ctrl.sv
// Per-BG mosaic strobes and yofs subtract from a double-buffered block size (MOSAIC_XY_SPLIT_EN splits h/v sizes).
// Outputs follow counters one cycle after a dot_en edge; bg_en acts combinationally; no backpressure.
module mosaic_ctrl
    import ppu_mosaic_pkg::*;
#(
    parameter int NUM_BG = 4,
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dot_en,
    input  logic                     newframe,
    input  logic                     newline,
    input  logic                     period_start,
    input  logic                     size_we,
    input  logic [SIZE_W-1:0]        size_wdata,
    input  logic [SIZE_W-1:0]        size_v_wdata,
    input  logic [NUM_BG-1:0]        bg_en,
    output logic [NUM_BG-1:0]        pixel_strobe,
    output logic [NUM_BG*SIZE_W-1:0] yofs_subtract,
    output logic                     mosaic_active
);

    logic [SIZE_W-1:0] size_pend;
    logic [SIZE_W-1:0] size_h_act;
    logic [SIZE_W-1:0] size_v_act;
    logic [SIZE_W-1:0] x_ctr;
    logic [SIZE_W-1:0] y_ctr;
    logic              pend_valid;
    logic              apply;

    assign apply = dot_en & (newline | newframe);

    // A write landing on the apply cycle bypasses the pending stage entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_pend  <= '0;
            size_h_act <= '0;
            pend_valid <= 1'b0;
        end else if (size_we && apply) begin
            size_h_act <= size_wdata;
            pend_valid <= 1'b0;
        end else if (size_we) begin
            size_pend  <= size_wdata;
            pend_valid <= 1'b1;
        end else if (apply && pend_valid) begin
            size_h_act <= size_pend;
            pend_valid <= 1'b0;
        end
    end

`ifdef MOSAIC_XY_SPLIT_EN
    logic [SIZE_W-1:0] size_v_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            size_v_pend <= '0;
            size_v_act  <= '0;
        end else if (size_we && apply) begin
            size_v_act  <= size_v_wdata;
        end else if (size_we) begin
            size_v_pend <= size_v_wdata;
        end else if (apply && pend_valid) begin
            size_v_act  <= size_v_pend;
        end
    end

    assign mosaic_active = (|bg_en) & (|(size_h_act | size_v_act));
`else
    logic unused_size_v;

    assign unused_size_v = ^size_v_wdata;
    assign size_v_act    = size_h_act;
    assign mosaic_active = (|bg_en) & (|size_h_act);
`endif

    // Counters compare against the act size held before any same-cycle apply.
    mosaic_axis_ctr #(.W(SIZE_W)) u_x_ctr (
        .clk   (clk),
        .reset (reset),
        .step  (dot_en),
        .clear (dot_en & period_start),
        .size  (size_h_act),
        .out   (x_ctr)
    );

    mosaic_axis_ctr #(.W(SIZE_W)) u_y_ctr (
        .clk   (clk),
        .reset (reset),
        .step  (dot_en & newline),
        .clear (dot_en & newframe),
        .size  (size_v_act),
        .out   (y_ctr)
    );

    always_comb begin
        pixel_strobe  = '0;
        yofs_subtract = '0;
        for (int i = 0; i < NUM_BG; i++) begin
            pixel_strobe[i]                  = ~bg_en[i] | (x_ctr == '0);
            yofs_subtract[i*SIZE_W +: SIZE_W] = bg_en[i] ? y_ctr : '0;
        end
    end

endmodule

// File: doc/mosaic_ctrl.md
# mosaic_ctrl

Multi-layer BG mosaic controller for the PPU. It is the parametrised successor of the single-size mosaic counter. It generates per-BG horizontal pixel strobes and vertical y-offset subtract values from a shared block size. Size writes are double-buffered so mid-line register writes never tear a block. Outputs feed each BG fetch unit: the strobe gates the BG's pixel hold latch, and the subtract value is removed from the BG's yofs before tile fetch.

## Interface
Parameters:
- NUM_BG, 4, number of BG layers served (1..8)
- SIZE_W, 4, width of block-size field; block edge = size+1 dots/lines

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dot_en  in  1  dot-rate qualifier; all counter and size-apply updates occur only when high
- newframe  in  1  frame start pulse (dot_en-qualified)
- newline  in  1  line start pulse (dot_en-qualified)
- period_start  in  1  first dot of active display on a line (dot_en-qualified)
- size_we  in  1  register write strobe (any clk cycle, not dot_en-qualified)
- size_wdata  in  SIZE_W  horizontal (and, without split, vertical) size
- size_v_wdata  in  SIZE_W  vertical size; used only with MOSAIC_XY_SPLIT_EN
- bg_en  in  NUM_BG  per-layer mosaic enable (level, sampled combinationally)
- pixel_strobe  out  NUM_BG  per-layer capture strobe
- yofs_subtract  out  NUM_BG*SIZE_W  per-layer subtract value; layer i occupies bits [i*SIZE_W +: SIZE_W]
- mosaic_active  out  1  high when any bg_en bit is set and the active size is non-zero

## Operation
Registers:
- size_pend and size_v_pend: pending size values.
- pend_valid: pending-write flag.
- size_h_act and size_v_act: active size values.
- x_ctr and y_ctr: counters, each SIZE_W wide.

Size writes and apply:
- size_we captures the write data into the pend registers and sets pend_valid.
- The apply event is dot_en & (newline | newframe). On apply with pend_valid=1, the pend values are copied to the act values and pend_valid is cleared.
- If size_we coincides with an apply, the new size_wdata goes straight to the act values (bypass), and pend_valid ends at 0.
- Without MOSAIC_XY_SPLIT_EN, size_v_act is always equal to size_h_act.

Horizontal counter (on dot_en):
- period_start sets x_ctr to 0.
- Otherwise, x_ctr becomes 0 if x_ctr >= size_h_act, else x_ctr+1.

Vertical counter (on dot_en):
- newframe sets y_ctr to 0. newframe has priority over newline.
- On newline, y_ctr becomes 0 if y_ctr >= size_v_act, else y_ctr+1. The compare uses the act value from before any same-cycle apply.
- The >= compare makes a size shrink wrap at once and never overruns.

Outputs (combinational from registers):
- pixel_strobe[i] = ~bg_en[i] | (x_ctr == 0).
- yofs_subtract[i] = bg_en[i] ? y_ctr : 0.
- Size 0 degenerates to no mosaic: the strobe is always 1 and the subtract value is always 0.

## Timing
- Reset: all counters, act and pend registers, and pend_valid are cleared. As a result pixel_strobe is all 1s, yofs_subtract is all 0, and mosaic_active is 0.
- Reset mid-block discards any pending write.
- Latency:
  - Counter changes are visible on outputs the cycle after the qualifying dot_en edge.
  - A size write takes effect on the counter compare in the dot after the next line or frame start.
- bg_en changes affect outputs in the same cycle. They do not disturb the counters.
- Counter width wraps naturally at 2^SIZE_W-1 only when size is all 1s. No overflow is possible, because wrap occurs at >= size.

## Configuration
- MOSAIC_XY_SPLIT_EN defined:
  - Independent vertical size from size_v_wdata, double-buffered in the same way as the horizontal size.
  - mosaic_active uses size_h_act | size_v_act.
- MOSAIC_XY_SPLIT_EN undefined:
  - size_v_wdata is ignored.
  - The vertical size tracks the horizontal size. This is the classic square mosaic.

## Structure
- Package ppu_mosaic_pkg:
  - Default SIZE_W.
  - typedef mosaic_size_t (logic [SIZE_W-1:0]).
  - Helper function unpacking a per-layer yofs slice.
- Sub-module mosaic_axis_ctr, instantiated twice (horizontal and vertical):
  - Ports: clk, reset, step, clear, size, out.
  - Behaviour: wrap-at->=size counter with priority clear.

## Test plan
- Reset with NUM_BG=4 -> pixel_strobe=4'b1111, all yofs_subtract=0, mosaic_active=0.
- Write size=3 mid-line, bg_en=4'b0001, then a newline -> strobe on BG0 only at x_ctr=0, i.e. every 4th dot after period_start. Over successive lines, yofs_subtract[0] follows the sequence 0,1,2,3,0. BG1-3 strobes stay 1 and their subtract values stay 0.
- With size=7 and y_ctr=6, write size=2 -> the next newline (old size 7, 6<7) gives y_ctr=7. The following newline (7>=2) gives y_ctr=0, with no value above 7 ever reached.
- size_we on the same cycle as a dot_en newline with wdata=5 -> size_h_act=5 immediately and pend_valid=0. A second write with no newline leaves the act value unchanged.
- newframe and newline together with y_ctr=2 -> y_ctr=0.
- MOSAIC_XY_SPLIT_EN with h=1 and v=3 -> strobe every 2 dots, and the y sequence wraps every 4 lines.
